// File: rtl/vending_pkg.sv
// Shared types and encodings for the vending datapath.
// The coin acceptor and vending_machine agree on the J encoding defined here.
package vending_pkg;

  typedef enum logic [2:0] {
    IDLE,
    QUAL,
    EMIT,
    WAIT_REL,
    GUARD
  } acc_state_t;

  localparam logic COIN_RS5  = 1'b0;
  localparam logic COIN_RS10 = 1'b1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for one asynchronous sensor line.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin sensor front end: synchronise, debounce and classify coins into one
// I/J event per coin, with reject and jam reporting.
module coin_acceptor
  import vending_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int JAM_CYCLES      = 64,
  parameter int GUARD_CYCLES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin5_raw,
  input  logic       coin10_raw,
  output logic       I,
  output logic       J,
  output logic       reject,
  output logic       jam,
  output logic [2:0] state_dbg
);

  localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, JAM_CYCLES, GUARD_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] JAM_LIM    = CNT_W'(JAM_CYCLES);
  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES);

  logic s5;
  logic s10;

  sync2 u_sync5  (.clk(clk), .reset(reset), .d(coin5_raw),  .q(s5));
  sync2 u_sync10 (.clk(clk), .reset(reset), .d(coin10_raw), .q(s10));

  acc_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             denom_q, denom_d;
  logic             i_q, i_d;
  logic             j_q, j_d;
  logic             reject_q, reject_d;
  logic             jam_q, jam_d;

  logic             cur_hi;
  logic             oth_hi;
  logic [CNT_W-1:0] cnt_inc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= GUARD;
      cnt_q    <= GUARD_LOAD;
      denom_q  <= COIN_RS5;
      i_q      <= 1'b0;
      j_q      <= 1'b0;
      reject_q <= 1'b0;
      jam_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      denom_q  <= denom_d;
      i_q      <= i_d;
      j_q      <= j_d;
      reject_q <= reject_d;
      jam_q    <= jam_d;
    end
  end

  // I is a one-cycle strobe with J qualified by it; there is no backpressure.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    denom_d  = denom_q;
    i_d      = 1'b0;
    j_d      = 1'b0;
    reject_d = 1'b0;
    jam_d    = 1'b0;
    cur_hi   = (denom_q == COIN_RS10) ? s10 : s5;
    oth_hi   = (denom_q == COIN_RS10) ? s5 : s10;
    cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (s5 && s10) begin
          reject_d = 1'b1;
          cnt_d    = '0;
          state_d  = WAIT_REL;
        end else if (s5 || s10) begin
          denom_d = s10 ? COIN_RS10 : COIN_RS5;
          cnt_d   = '0;
          state_d = QUAL;
        end
      end
      QUAL: begin
        if (!cur_hi) begin
          state_d = IDLE;
        end else if (oth_hi) begin
          reject_d = 1'b1;
          cnt_d    = '0;
          state_d  = WAIT_REL;
        end else if (cnt_q == DEB_LAST) begin
          i_d     = 1'b1;
          j_d     = denom_q;
          state_d = EMIT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      EMIT: begin
        cnt_d   = '0;
        state_d = WAIT_REL;
      end
      WAIT_REL: begin
        if (!s5 && !s10) begin
          cnt_d   = GUARD_LOAD;
          state_d = GUARD;
        end else begin
          cnt_d = cnt_inc;
          jam_d = (cnt_inc >= JAM_LIM);
        end
      end
      GUARD: begin
        // Any activity during the guard restarts the release wait, so an
        // overlapping second coin can never slip through uncredited-then-credited.
        if (s5 || s10) begin
          cnt_d   = '0;
          state_d = WAIT_REL;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = GUARD;
        cnt_d   = GUARD_LOAD;
      end
    endcase
  end

  assign I         = i_q;
  assign J         = j_q;
  assign reject    = reject_q;
  assign jam       = jam_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: expected output events are derived from coin
// durations and latencies, queued, and matched by an independent monitor.
module tb_coin_acceptor;
  import vending_pkg::*;

  localparam int DEB  = 4;
  localparam int JAMC = 64;
  localparam int GRD  = 2;
  localparam int W    = 35;

  localparam logic [2:0] EV_I5  = 3'd0;
  localparam logic [2:0] EV_I10 = 3'd1;
  localparam logic [2:0] EV_REJ = 3'd2;
  localparam logic [2:0] EV_JR  = 3'd3;
  localparam logic [2:0] EV_JF  = 3'd4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       coin5_raw = 1'b0;
  logic       coin10_raw = 1'b0;
  logic       I;
  logic       J;
  logic       reject;
  logic       jam;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];
  logic jam_prev = 1'b0;

  coin_acceptor #(
    .DEBOUNCE_CYCLES(DEB),
    .JAM_CYCLES(JAMC),
    .GUARD_CYCLES(GRD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .coin5_raw(coin5_raw),
    .coin10_raw(coin10_raw),
    .I(I),
    .J(J),
    .reject(reject),
    .jam(jam),
    .state_dbg(state_dbg)
  );

  // clock / cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // scoreboard
  task automatic push_ev(input logic [2:0] code, input int at);
    exp_q.push_back({code, 32'(at)});
  endtask

  task automatic see(input logic [2:0] code);
    logic [W-1:0] got;
    logic [W-1:0] want;
    got = {code, 32'(cyc)};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event: got code %0d at cycle %0d, required no event", code, cyc);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        errors++;
        $display("FAIL event: got code %0d at cycle %0d, required code %0d at cycle %0d",
                 got[34:32], got[31:0], want[34:32], want[31:0]);
      end
    end
  endtask

  task automatic check_val(input string name, input logic [2:0] got, input logic [2:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (I === 1'b1) begin
      see(J ? EV_I10 : EV_I5);
    end else begin
      checks++;
      if (J !== 1'b0) begin
        errors++;
        $display("FAIL j_idle: got %b at cycle %0d, required 0", J, cyc);
      end
    end
    if (reject === 1'b1) see(EV_REJ);
    if (jam !== jam_prev) see((jam === 1'b1) ? EV_JR : EV_JF);
    jam_prev = jam;
  end

  // drivers and reference model (called at a negedge)
  task automatic hold(input logic v5, input logic v10, input int n);
    coin5_raw  = v5;
    coin10_raw = v10;
    repeat (n) @(negedge clk);
  endtask

  task automatic gap(input int n);
    hold(1'b0, 1'b0, n);
  endtask

  // One sensor high for len cycles: credited when len >= DEB+1, seen DEB+2
  // edges after the rise; WAIT_REL starts DEB+3 edges after the rise.
  task automatic single(input logic den, input int len);
    int c;
    c = cyc;
    if (len >= DEB + 1) begin
      push_ev(den ? EV_I10 : EV_I5, c + 1 + DEB + 2);
      if (len + 1 >= DEB + 3 + JAMC) begin
        push_ev(EV_JR, c + 1 + DEB + 3 + JAMC);
        push_ev(EV_JF, c + 1 + len + 2);
      end
    end
    hold(!den, den, len);
  endtask

  task automatic both(input int len);
    int c;
    c = cyc;
    push_ev(EV_REJ, c + 1 + 2);
    if (len + 1 >= 2 + JAMC) begin
      push_ev(EV_JR, c + 1 + 2 + JAMC);
      push_ev(EV_JF, c + 1 + len + 2);
    end
    hold(1'b1, 1'b1, len);
  endtask

  // Rs.5 rises, Rs.10 joins k cycles later while still qualifying.
  task automatic late_reject(input int k, input int len);
    int c;
    c = cyc;
    push_ev(EV_REJ, c + 1 + k + 2);
    hold(1'b1, 1'b0, k);
    hold(1'b1, 1'b1, len - k);
  endtask

  initial begin
    int kind;
    int k;
    logic den;

    repeat (3) @(negedge clk);
    check_val("reset_i", {2'b0, I}, 3'd0);
    check_val("reset_j", {2'b0, J}, 3'd0);
    check_val("reset_reject", {2'b0, reject}, 3'd0);
    check_val("reset_jam", {2'b0, jam}, 3'd0);
    check_val("reset_state", state_dbg, 3'(GUARD));
    reset = 1'b0;
    gap(6);

    single(1'b0, 10); gap(8);
    single(1'b1, 10); gap(5); single(1'b0, 10); gap(8);
    single(1'b0, 3); gap(2); single(1'b0, 3); gap(8);
    both(4); gap(6); single(1'b1, 8); gap(8);
    single(1'b1, 100); gap(8);

    // coin already present when reset releases
    reset = 1'b1;
    coin10_raw = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    hold(1'b0, 1'b1, 20); gap(8);
    single(1'b0, 10); gap(8);

    // reset pulsed mid-qualification
    hold(1'b1, 1'b0, 4);
    reset = 1'b1;
    #1;
    check_val("midqual_i", {2'b0, I}, 3'd0);
    check_val("midqual_state", state_dbg, 3'(GUARD));
    @(negedge clk);
    hold(1'b1, 1'b0, 2);
    reset = 1'b0;
    hold(1'b1, 1'b0, 10); gap(8);
    single(1'b1, 10); gap(8);

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      den  = 1'($urandom_range(0, 1));
      case (kind)
        0, 1, 2, 3: single(den, $urandom_range(DEB + 1, DEB + 10));
        4:          single(den, $urandom_range(1, DEB));
        5:          both($urandom_range(1, 8));
        6: begin
          k = $urandom_range(1, DEB);
          late_reject(k, k + $urandom_range(1, 6));
        end
        7:          single(den, DEB + 1);
        8:          single(den, $urandom_range(DEB + JAMC, DEB + JAMC + 6));
        default:    single(den, DEB);
      endcase
      gap($urandom_range(GRD + 3, GRD + 10));
    end

    gap(40);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d events still expected, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
